// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM state type, iteration count and small op-decode helpers.
package mdu_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    localparam int MDU_ITERS = 32;
    localparam int CNT_W     = $clog2(MDU_ITERS);
    localparam logic [CNT_W-1:0] ITER_LAST = CNT_W'(MDU_ITERS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10,
        S_DONE = 2'b11
    } mdu_state_e;

    // Signed ops take operand magnitudes and need a sign fix at the end.
    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    // Both divide encodings share the upper op bit.
    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/mdu_core.sv
// Iterative datapath: shift-add multiply and restoring divide sharing one
// adder/subtractor, plus the final sign correction of the result.
module mdu_core
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic             fix,
    input  logic             is_div,
    input  logic             neg_q,
    input  logic             neg_r,
    input  logic [WIDTH-1:0] load_lo,
    input  logic [WIDTH-1:0] load_opnd,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    localparam logic [WIDTH-1:0]   ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ONE_2W = {{(2*WIDTH-1){1'b0}}, 1'b1};

    // acc: product high half / partial remainder; lo: multiplier / quotient
    logic [WIDTH-1:0]   acc_r;
    logic [WIDTH-1:0]   lo_r;
    logic [WIDTH-1:0]   opnd_r;
    logic [WIDTH:0]     rem_sh_s;
    logic [WIDTH:0]     add_a_s;
    logic [WIDTH:0]     add_b_s;
    logic [WIDTH+1:0]   sum_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0] prod_fix_s;

    // Shared adder: add multiplicand, or subtract divisor with carry-out as no-borrow
    always_comb begin
        rem_sh_s = {acc_r, lo_r[WIDTH-1]};
        if (is_div) begin
            add_a_s = rem_sh_s;
            add_b_s = ~{1'b0, opnd_r};
        end else begin
            add_a_s = {1'b0, acc_r};
            add_b_s = {1'b0, opnd_r};
        end
        sum_s = {1'b0, add_a_s} + {1'b0, add_b_s} + {{(WIDTH+1){1'b0}}, is_div};
    end

    // Operand load and one multiply/divide iteration per step strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r  <= {WIDTH{1'b0}};
            lo_r   <= {WIDTH{1'b0}};
            opnd_r <= {WIDTH{1'b0}};
        end else if (load) begin
            acc_r  <= {WIDTH{1'b0}};
            lo_r   <= load_lo;
            opnd_r <= load_opnd;
        end else if (step) begin
            if (is_div) begin
                if (sum_s[WIDTH+1]) begin
                    acc_r <= sum_s[WIDTH-1:0];
                    lo_r  <= {lo_r[WIDTH-2:0], 1'b1};
                end else begin
                    acc_r <= rem_sh_s[WIDTH-1:0];
                    lo_r  <= {lo_r[WIDTH-2:0], 1'b0};
                end
            end else begin
                if (lo_r[0]) begin
                    acc_r <= sum_s[WIDTH:1];
                    lo_r  <= {sum_s[0], lo_r[WIDTH-1:1]};
                end else begin
                    acc_r <= {1'b0, acc_r[WIDTH-1:1]};
                    lo_r  <= {acc_r[0], lo_r[WIDTH-1:1]};
                end
            end
        end else begin
            acc_r  <= acc_r;
            lo_r   <= lo_r;
            opnd_r <= opnd_r;
        end
    end

    // Sign correction applied while the fix strobe is high
    always_comb begin
        prod_s = {acc_r, lo_r};
        if (fix && neg_q) begin
            prod_fix_s = ~prod_s + ONE_2W;
        end else begin
            prod_fix_s = prod_s;
        end
        if (is_div) begin
            if (fix && neg_r) begin
                res_hi = ~acc_r + ONE_W;
            end else begin
                res_hi = acc_r;
            end
            if (fix && neg_q) begin
                res_lo = ~lo_r + ONE_W;
            end else begin
                res_lo = lo_r;
            end
        end else begin
            res_hi = prod_fix_s[2*WIDTH-1:WIDTH];
            res_lo = prod_fix_s[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/mdu_muldiv.sv
// Multiply/divide unit top: start/busy/done FSM, iteration counter,
// sign flags and the architectural HI/LO registers.
module mdu_muldiv
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam logic [WIDTH-1:0] ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] ONE_C = {{(CNT_W-1){1'b0}}, 1'b1};

    mdu_state_e       state_r;
    mdu_state_e       next_state_s;
    logic [CNT_W-1:0] cnt_r;
    logic             is_div_r, neg_q_r, neg_r_r;
    logic             load_s, step_s, fix_s;
    logic             is_signed_s, is_div_s, sign1_s, sign2_s, div_zero_s;
    logic [WIDTH-1:0] mag1_s, mag2_s, load_lo_s, load_opnd_s;
    logic [WIDTH-1:0] res_hi_s, res_lo_s;
    logic             busy_r, done_r;
    logic [WIDTH-1:0] hi_r, lo_r;

    // Operand decode: magnitudes for signed ops, routing into the core
    always_comb begin
        is_signed_s = op_is_signed(op_i);
        is_div_s    = op_is_div(op_i);
        sign1_s     = is_signed_s & src1_i[WIDTH-1];
        sign2_s     = is_signed_s & src2_i[WIDTH-1];
        mag1_s      = sign1_s ? (~src1_i + ONE_W) : src1_i;
        mag2_s      = sign2_s ? (~src2_i + ONE_W) : src2_i;
        div_zero_s  = is_div_s & (src2_i == {WIDTH{1'b0}});
        if (is_div_s) begin
            load_lo_s   = mag1_s;
            load_opnd_s = mag2_s;
        end else begin
            load_lo_s   = mag2_s;
            load_opnd_s = mag1_s;
        end
    end

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next state and datapath strobes
    always_comb begin
        next_state_s = state_r;
        load_s       = 1'b0;
        step_s       = 1'b0;
        fix_s        = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (start_i) begin
                    next_state_s = S_CALC;
                    load_s       = 1'b1;
                end else begin
                    next_state_s = S_IDLE;
                end
            end
            S_CALC: begin
                step_s = 1'b1;
                if (cnt_r == {CNT_W{1'b0}}) begin
                    next_state_s = S_FIX;
                end else begin
                    next_state_s = S_CALC;
                end
            end
            S_FIX: begin
                fix_s        = 1'b1;
                next_state_s = S_DONE;
            end
            S_DONE: begin
                next_state_s = S_IDLE;
            end
            default: begin
                next_state_s = S_IDLE;
            end
        endcase
    end

    // Iteration counter and sign flags captured at acceptance.
    // A zero divisor keeps the all-ones quotient positive; the remainder
    // sign fix then restores the original dividend into HI.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_r    <= {CNT_W{1'b0}};
            is_div_r <= 1'b0;
            neg_q_r  <= 1'b0;
            neg_r_r  <= 1'b0;
        end else if (load_s) begin
            cnt_r    <= ITER_LAST;
            is_div_r <= is_div_s;
            neg_q_r  <= (sign1_s ^ sign2_s) & ~div_zero_s;
            neg_r_r  <= sign1_s;
        end else if (step_s && (cnt_r != {CNT_W{1'b0}})) begin
            cnt_r <= cnt_r - ONE_C;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    mdu_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk      (clk_i),
        .rst_n    (rst_i),
        .load     (load_s),
        .step     (step_s),
        .fix      (fix_s),
        .is_div   (is_div_r),
        .neg_q    (neg_q_r),
        .neg_r    (neg_r_r),
        .load_lo  (load_lo_s),
        .load_opnd(load_opnd_s),
        .res_hi   (res_hi_s),
        .res_lo   (res_lo_s)
    );

    // Registered handshake outputs and HI/LO result pair
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
            hi_r   <= {WIDTH{1'b0}};
            lo_r   <= {WIDTH{1'b0}};
        end else begin
            busy_r <= (next_state_s != S_IDLE);
            done_r <= fix_s;
            if (fix_s) begin
                hi_r <= res_hi_s;
                lo_r <= res_lo_s;
            end else begin
                hi_r <= hi_r;
                lo_r <= lo_r;
            end
        end
    end

    assign busy_o = busy_r;
    assign done_o = done_r;
    assign hi_o   = hi_r;
    assign lo_o   = lo_r;

endmodule

// File: tb/tb_mdu_muldiv.sv
// Self-checking bench for mdu_muldiv: directed cases, handshake/reset
// behaviour and randomized ops against an arithmetic reference model.
module tb_mdu_muldiv;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad   = 0;

    mdu_muldiv #(.WIDTH(32)) dut (
        .clk_i  (clk),
        .rst_i  (rst_n),
        .start_i(start),
        .op_i   (op),
        .src1_i (src1),
        .src2_i (src2),
        .busy_o (busy),
        .done_o (done),
        .hi_o   (hi),
        .lo_o   (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference results from plain arithmetic on the ISA definition
    function automatic void model(input logic [1:0] mop, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] mhi, output logic [31:0] mlo);
        logic [63:0] p;
        int sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        p  = 64'd0;
        mhi = 32'd0;
        mlo = 32'd0;
        case (mop)
            2'b00: begin
                p = longint'(sa) * longint'(sb);
                mhi = p[63:32]; mlo = p[31:0];
            end
            2'b01: begin
                p = {32'd0, a} * {32'd0, b};
                mhi = p[63:32]; mlo = p[31:0];
            end
            2'b10: begin
                if (b == 32'd0) begin
                    mlo = 32'hFFFF_FFFF; mhi = a;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    mlo = 32'h8000_0000; mhi = 32'd0;
                end else begin
                    mlo = sa / sb; mhi = sa % sb;
                end
            end
            default: begin
                if (b == 32'd0) begin
                    mlo = 32'hFFFF_FFFF; mhi = a;
                end else begin
                    mlo = a / b; mhi = a % b;
                end
            end
        endcase
    endfunction

    function automatic logic [31:0] pick_operand();
        logic [31:0] v;
        case ($urandom_range(7, 0))
            0:       v = 32'd0;
            1:       v = 32'h8000_0000;
            2:       v = 32'hFFFF_FFFF;
            3:       v = 32'd1;
            4:       v = 32'($urandom_range(20, 0));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // Issue one op and watch 35 sample points after the accepting edge E0.
    // Sample k is taken at the falling edge after edge Ek.
    task automatic run_op(input string tag, input logic [1:0] top, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input int inj1, input int inj2);
        int busy_n, done_n, done_at;
        logic busy_end;
        logic [31:0] hi_d, lo_d, hi_end, lo_end;
        busy_n = 0; done_n = 0; done_at = -1; busy_end = 1'b1;
        hi_d = 32'hDEAD_BEEF; lo_d = 32'hDEAD_BEEF; hi_end = 32'd0; lo_end = 32'd0;
        @(negedge clk);
        start = 1'b1; op = top; src1 = a; src2 = b;
        @(posedge clk);
        for (int k = 0; k <= 34; k++) begin
            @(negedge clk);
            if (busy === 1'b1) busy_n++;
            if (done === 1'b1) begin
                done_n++;
                if (done_at < 0) begin
                    done_at = k; hi_d = hi; lo_d = lo;
                end
            end
            if (k == 34) begin
                busy_end = busy; hi_end = hi; lo_end = lo;
            end
            if (k == inj1 || k == inj2) begin
                start = 1'b1; op = 2'($urandom_range(3, 0)); src1 = $urandom; src2 = $urandom;
            end else begin
                start = 1'b0; src1 = $urandom; src2 = $urandom;
            end
        end
        check({tag, ".latency"}, 32'(done_at), 32'd33);
        check({tag, ".done_pulses"}, 32'(done_n), 32'd1);
        check({tag, ".busy_cycles"}, 32'(busy_n), 32'd34);
        check({tag, ".busy_fall"}, {31'd0, busy_end}, 32'd0);
        check({tag, ".hi"}, hi_d, exp_hi);
        check({tag, ".lo"}, lo_d, exp_lo);
        check({tag, ".hi_hold"}, hi_end, exp_hi);
        check({tag, ".lo_hold"}, lo_end, exp_lo);
    endtask

    initial begin
        logic [1:0]  rop;
        logic [31:0] ra, rb, mh, ml;
        int busy_seen, done_seen;

        rst_n = 1'b0; start = 1'b0; op = 2'b00; src1 = 32'd0; src2 = 32'd0;
        repeat (3) @(negedge clk);
        check("reset.busy", {31'd0, busy}, 32'd0);
        check("reset.done", {31'd0, done}, 32'd0);
        check("reset.hi", hi, 32'd0);
        check("reset.lo", lo, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle.busy", {31'd0, busy}, 32'd0);

        // Directed cases from the ISA examples
        run_op("mult_7x-3", 2'b00, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, -1, -1);
        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, -1, -1);
        run_op("div_-7/2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, -1, -1);
        run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, -1, -1);
        run_op("divu_by0", 2'b11, 32'd100, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF, -1, -1);
        run_op("div_neg_by0", 2'b10, 32'hFFFF_FF9C, 32'd0, 32'hFFFF_FF9C, 32'hFFFF_FFFF, -1, -1);

        // Starts while busy (mid-CALC and in the DONE cycle) are ignored
        run_op("hs_mult", 2'b00, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 4, 33);
        busy_seen = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (busy === 1'b1) busy_seen++;
        end
        check("hs.no_requeue", 32'(busy_seen), 32'd0);
        check("hs.hi_kept", hi, 32'hFFFF_FFFF);

        // Asynchronous reset in the middle of a divide
        @(negedge clk);
        start = 1'b1; op = 2'b10; src1 = 32'd1000; src2 = 32'd7;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("rst.busy_before", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst.busy", {31'd0, busy}, 32'd0);
        check("rst.done", {31'd0, done}, 32'd0);
        check("rst.hi", hi, 32'd0);
        check("rst.lo", lo, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        busy_seen = 0; done_seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (busy === 1'b1) busy_seen++;
            if (done === 1'b1) done_seen++;
        end
        check("rst.no_done", 32'(done_seen), 32'd0);
        check("rst.no_busy", 32'(busy_seen), 32'd0);
        run_op("post_rst_divu", 2'b11, 32'd1000, 32'd7, 32'd6, 32'd142, -1, -1);

        // Randomized ops against the reference model
        for (int n = 0; n < 24; n++) begin
            rop = 2'($urandom_range(3, 0));
            ra  = pick_operand();
            rb  = pick_operand();
            model(rop, ra, rb, mh, ml);
            run_op($sformatf("rand%0d_op%0d", n, rop), rop, ra, rb, mh, ml, -1, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
